// File: rtl/arm_motion_recorder.sv
// Accelerometer trajectory recorder with looping playback.
// Samples x/y/z into RAM on a fixed tick and replays them.
module arm_motion_recorder #(
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              btn_rec,
  input  logic              btn_play,
  input  logic [7:0]        data_accel_x,
  input  logic [7:0]        data_accel_y,
  input  logic [7:0]        data_accel_z,
  output logic [7:0]        rec_data_x,
  output logic [7:0]        rec_data_y,
  output logic [7:0]        rec_data_z,
  output logic              rec_active,
  output logic              play_active,
  output logic              mem_full,
  output logic [ADDR_W:0]   rec_len
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY
  } state_t;

  state_t state;
  state_t next;

  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       mem [DEPTH];
  logic              lock;
  logic              tick;
  logic              wr_en;
  logic              fill;
  logic              enter_rec;
  logic              enter_play;

  assign tick       = (cnt == CMAX);
  assign wr_en      = (state == RECORD) && tick
                      && enable && btn_rec;
  assign fill       = wr_en && (rec_len == LAST);
  assign enter_rec  = (next == RECORD) && (state != RECORD);
  assign enter_play = (next == PLAY) && (state != PLAY);

  assign rec_active  = (state == RECORD);
  assign play_active = (state == PLAY);

  // Next-state decode; record wins over play.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (enable && btn_rec && !lock)
          next = RECORD;
        else if (enable && btn_play && !btn_rec
                 && rec_len != '0)
          next = PLAY;
      end
      RECORD: begin
        if (!enable || !btn_rec || fill)
          next = IDLE;
      end
      PLAY: begin
        if (enable && btn_rec && !lock)
          next = RECORD;
        else if (!enable || !btn_play)
          next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  // Sample-period counter, restarted on every mode entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (enter_rec || enter_play || state == IDLE)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // Write pointer, length and full flag of the current take.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr  <= '0;
      rec_len  <= '0;
      mem_full <= 1'b0;
    end else if (enter_rec) begin
      wr_addr  <= '0;
      rec_len  <= '0;
      mem_full <= 1'b0;
    end else if (wr_en) begin
      rec_len <= rec_len + 1'b1;
      if (fill) mem_full <= 1'b1;
      else      wr_addr  <= wr_addr + 1'b1;
    end
  end

  // A take that fills memory ends it; btn_rec must drop
  // before a new take can start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          lock <= 1'b0;
    else if (!btn_rec) lock <= 1'b0;
    else if (fill)     lock <= 1'b1;
  end

  // Playback pointer loops over the recorded length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_addr <= '0;
    else if (enter_play)
      rd_addr <= '0;
    else if (state == PLAY && tick) begin
      if ({1'b0, rd_addr} == rec_len - 1'b1)
        rd_addr <= '0;
      else
        rd_addr <= rd_addr + 1'b1;
    end
  end

  // Sample RAM write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= {data_accel_x, data_accel_y,
                       data_accel_z};
  end

  // Registered read; outputs forced to zero outside PLAY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      {rec_data_x, rec_data_y, rec_data_z} <= '0;
    else if (state == PLAY)
      {rec_data_x, rec_data_y, rec_data_z} <= mem[rd_addr];
    else
      {rec_data_x, rec_data_y, rec_data_z} <= '0;
  end

endmodule

// File: tb/tb_arm_motion_recorder.sv
// Directed bench for arm_motion_recorder
// (ADDR_W=3, TICK_DIV=4).
module tb_arm_motion_recorder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable, btn_rec, btn_play;
  logic [7:0] ax, ay, az;
  logic [7:0] rx, ry, rz;
  logic       rec_active, play_active, mem_full;
  logic [3:0] rec_len;

  arm_motion_recorder #(.ADDR_W(3), .TICK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .btn_rec      (btn_rec),
    .btn_play     (btn_play),
    .data_accel_x (ax),
    .data_accel_y (ay),
    .data_accel_z (az),
    .rec_data_x   (rx),
    .rec_data_y   (ry),
    .rec_data_z   (rz),
    .rec_active   (rec_active),
    .play_active  (play_active),
    .mem_full     (mem_full),
    .rec_len      (rec_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rec;
    logic        play;
    logic [23:0] acc;
    logic [30:0] exp;
  } vec_t;

  vec_t vq[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [23:0] samp(input int k);
    logic [7:0] x;
    x = 8'(16 * (k + 1));
    return {x, x + 8'd1, x + 8'd2};
  endfunction

  function automatic void add(
    input logic en, input logic rec, input logic play,
    input logic [23:0] acc, input logic [23:0] dat,
    input logic ra, input logic pa, input logic full,
    input logic [3:0] len);
    vec_t v;
    v.en   = en;
    v.rec  = rec;
    v.play = play;
    v.acc  = acc;
    v.exp  = {dat, ra, pa, full, len};
    vq.push_back(v);
  endfunction

  function automatic logic [30:0] outs();
    return {rx, ry, rz, rec_active, play_active,
            mem_full, rec_len};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Record 3 samples then loop them.
    add(1, 1, 0, samp(0), 24'h0, 1, 0, 0, 4'd0);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++)
        add(1, 1, 0, samp(k), 24'h0, 1, 0, 0,
            4'((c == 3) ? k + 1 : k));
    add(1, 0, 0, samp(2), 24'h0, 0, 0, 0, 4'd3);
    add(1, 0, 1, samp(2), 24'h0, 0, 1, 0, 4'd3);
    for (int i = 0; i < 16; i++)
      add(1, 0, 1, samp(2), samp((i / 4) % 3),
          0, 1, 0, 4'd3);
    add(1, 0, 0, samp(2), 24'h202122, 0, 0, 0, 4'd3);
    add(1, 0, 0, samp(2), 24'h0, 0, 0, 0, 4'd3);

    enable   = 1'b1;
    btn_rec  = 1'b1;
    btn_play = 1'b1;
    {ax, ay, az} = 24'h0;
    #1 rst = 1'b0;
    #2 chk("reset_async", 64'(outs()), 64'h0);
    step(2);
    chk("reset_held", 64'(outs()), 64'h0);
    enable = 1'b0;
    rst    = 1'b1;
    step(3);
    chk("idle_disabled", 64'(outs()), 64'h0);
    btn_rec  = 1'b0;
    btn_play = 1'b0;
    step(1);

    foreach (vq[i]) begin
      enable   = vq[i].en;
      btn_rec  = vq[i].rec;
      btn_play = vq[i].play;
      {ax, ay, az} = vq[i].acc;
      step(1);
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'(vq[i].exp));
    end

    // Fill memory: 12 ticks held, only 8 writes.
    btn_rec = 1'b1;
    step(1);
    chk("full_entry", 64'({rec_active, mem_full, rec_len}),
        64'({1'b1, 1'b0, 4'd0}));
    for (int k = 0; k < 12; k++) begin
      ax = 8'(8'h80 + k);
      ay = 8'(8'h40 + k);
      az = 8'(8'hC0 + k);
      step(4);
      if (k < 7)
        chk($sformatf("full_len%0d", k), 64'(rec_len),
            64'(k + 1));
      if (k == 7)
        chk("full_stop",
            64'({rec_active, mem_full, rec_len}),
            64'({1'b0, 1'b1, 4'd8}));
    end
    chk("full_hold",
        64'({rec_active, play_active, mem_full, rec_len}),
        64'({1'b0, 1'b0, 1'b1, 4'd8}));

    btn_rec  = 1'b0;
    btn_play = 1'b1;
    step(1);
    chk("full_play", 64'(play_active), 64'h1);
    step(1);
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("full_loop%0d", j),
          64'({rx, ry, rz}),
          64'({8'(8'h80 + j % 8), 8'(8'h40 + j % 8),
               8'(8'hC0 + j % 8)}));
      step(4);
    end

    // Record button during playback.
    btn_rec = 1'b1;
    step(1);
    chk("play_to_rec",
        64'({rec_active, play_active, mem_full, rec_len}),
        64'({1'b1, 1'b0, 1'b0, 4'd0}));
    step(1);
    chk("rec_data_clr", 64'({rx, ry, rz}), 64'h0);
    step(7);
    chk("abort_two", 64'(rec_len), 64'd2);
    step(2);
    enable = 1'b0;
    step(1);
    chk("abort_idle", 64'({rec_active, rec_len}),
        64'({1'b0, 4'd2}));
    enable = 1'b1;
    step(1);
    chk("both_btn",
        64'({rec_active, play_active, rec_len}),
        64'({1'b1, 1'b0, 4'd0}));
    btn_rec  = 1'b0;
    btn_play = 1'b0;
    step(1);

    // Empty memory, then reset in the middle of playback.
    rst = 1'b0;
    #2 rst = 1'b1;
    btn_play = 1'b1;
    step(3);
    chk("empty_play", 64'(outs()), 64'h0);
    btn_play = 1'b0;
    btn_rec  = 1'b1;
    {ax, ay, az} = 24'h556677;
    step(9);
    chk("rec_two", 64'(rec_len), 64'd2);
    btn_rec  = 1'b0;
    btn_play = 1'b1;
    step(2);
    chk("play_two", 64'({play_active, rec_len}),
        64'({1'b1, 4'd2}));
    step(1);
    chk("play_first", 64'({rx, ry, rz}), 64'h556677);
    step(2);
    rst = 1'b0;
    #2 chk("reset_mid", 64'(outs()), 64'h0);
    rst      = 1'b1;
    btn_play = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_motion_recorder.md
Name: arm_motion_recorder

Overview:
- Records live accelerometer x/y/z samples into on-chip RAM at a fixed sample rate.
- Plays the recorded trajectory back in a continuous loop.
- Is the writer/producer side of the arm's memory path: its playback outputs feed the rom_data_x/y/z inputs of the arm mode-select state machine, and its sample inputs come from the same accelerometer bus.

Parameters:
- ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W samples (each 24 bits: {x,y,z}).
- TICK_DIV, 50000, clk cycles per sample period (must be >= 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  global enable; 0 forces IDLE.
- btn_rec  in  1  level record request, synchronised/debounced upstream.
- btn_play  in  1  level playback request, synchronised/debounced upstream.
- data_accel_x/y/z  in  8 each  live accelerometer samples.
- rec_data_x/y/z  out  8 each  playback sample, registered.
- rec_active  out  1  high while in RECORD.
- play_active  out  1  high while in PLAY.
- mem_full  out  1  last recording reached DEPTH samples.
- rec_len  out  ADDR_W+1  number of valid recorded samples.

Behaviour:
- Reset (rst=0, async): state=IDLE, tick counter=0, wr_addr=0, rd_addr=0, rec_len=0, mem_full=0, rec_active=0, play_active=0, rec_data_x/y/z=0. RAM contents are not cleared and are don't-care.
- States: IDLE, RECORD, PLAY. State is registered; next-state logic is combinational.
- IDLE transitions:
  - enable=1 & btn_rec=1 -> RECORD. Record has priority over play when both buttons are high.
  - enable=1 & btn_rec=0 & btn_play=1 & rec_len!=0 -> PLAY.
  - btn_play with rec_len=0 is ignored; stay in IDLE.
- RECORD:
  - On entry: rec_len<=0, wr_addr<=0, mem_full<=0, tick counter<=0.
  - Tick counter counts 0..TICK_DIV-1 and wraps. A tick occurs when counter==TICK_DIV-1, so the first write happens TICK_DIV cycles after the entry edge.
  - On each tick: mem[wr_addr] <= {data_accel_x, data_accel_y, data_accel_z}; wr_addr++; rec_len++.
  - The tick that makes rec_len==DEPTH sets mem_full=1 and the next state is IDLE. No further writes; wr_addr never wraps.
  - btn_rec=0 or enable=0 -> IDLE. rec_len keeps the count of completed writes. A partial tick period is discarded.
- PLAY:
  - On entry: rd_addr<=0, tick counter<=0. rec_data shows mem[0] from the first cycle after entry (1-cycle registered RAM read latency).
  - On each tick: if rd_addr==rec_len-1 then rd_addr<=0 (loop), else rd_addr++. rec_data follows one cycle after each rd_addr change.
  - btn_rec=1 & enable=1 -> RECORD directly (priority).
  - btn_play=0 or enable=0 -> IDLE.
- Outputs:
  - rec_data_x/y/z=0 whenever state!=PLAY (registered, so they clear one cycle after leaving PLAY).
  - rec_active/play_active decode the current state.
  - rec_len and mem_full hold their values outside RECORD.
- Reset mid-operation: immediate return to reset values; any recording is lost (rec_len=0).
- Arithmetic: all counters are unsigned. rec_len saturates at DEPTH by construction.

Test Plan (ADDR_W=3, DEPTH=8, TICK_DIV=4):
- Reset: assert rst=0 with buttons high -> all outputs 0, rec_active=play_active=0. Release rst with enable=0 -> remains IDLE.
- Record 3: enable=1, btn_rec=1; accel x/y/z = 0x10/0x11/0x12, then 0x20/0x21/0x22, then 0x30/0x31/0x32, each presented for one tick; drop btn_rec after the 3rd tick -> rec_len=3, mem_full=0, rec_active low one cycle after release.
- Loop playback: btn_play=1 -> rec_data_x sequence 0x10,0x20,0x30,0x10,0x20..., each held 4 cycles; y/z track x with the matching sample. Drop btn_play -> rec_data=0 and play_active=0.
- Full: hold btn_rec for 12 ticks with x incrementing per tick -> exactly 8 writes, mem_full=1, state IDLE after the 8th tick, rec_len=8. Subsequent playback loops all 8 samples.
- Priority/abort:
  - btn_rec=btn_play=1 from IDLE -> RECORD.
  - enable=0 after 2 ticks -> IDLE with rec_len=2.
  - btn_rec during PLAY -> RECORD with rec_len cleared to 0.
- Empty/reset: after reset, btn_play=1 -> stays IDLE, rec_data=0. Record 2 samples, enter PLAY, assert rst mid-tick -> all outputs 0, rec_len=0.
